// File: rtl/register_file_init_pkg.sv
// Shared constants for the decode-stage register file: FSM state encoding and default sizes.
package register_file_init_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/register_file_init_if.sv
// Read/write bus of the register file; the master drives indices and write data, the slave returns read data.
interface register_file_init_if
   import register_file_init_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
   // No handshake: writes land on the edge when regWrite=1 and ready=1;
   // readData1/2 are combinational and only meaningful while ready=1.
   logic [ADDR_WIDTH-1:0] readRegister1;
   logic [ADDR_WIDTH-1:0] readRegister2;
   logic [ADDR_WIDTH-1:0] writeRegister;
   logic [DATA_WIDTH-1:0] writeData;
   logic                  regWrite;
   logic [DATA_WIDTH-1:0] readData1;
   logic [DATA_WIDTH-1:0] readData2;
   logic                  ready;
   state_t                dbg_state;

   modport master (
      output readRegister1, readRegister2, writeRegister, writeData, regWrite,
      input  readData1, readData2, ready, dbg_state
   );

   modport slave (
      input  readRegister1, readRegister2, writeRegister, writeData, regWrite,
      output readData1, readData2, ready, dbg_state
   );

endinterface

// File: rtl/register_file_init_read_port.sv
// One read port: gates output during init, hardwires entry 0, and forwards same-cycle write data.
module regfile_read_port #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                  i_ready,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   input  logic [DATA_WIDTH-1:0] i_stored,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   always_comb begin
      o_rdata = i_stored;
      if (!i_ready) begin
         o_rdata = '0;
      end else if (ZERO_REG && (i_raddr == '0)) begin
         o_rdata = '0;
      end else if (BYPASS && i_we && (i_raddr == i_waddr)) begin
         o_rdata = i_wdata;
      end
   end

endmodule

// File: rtl/register_file_init.sv
// Parametrised register file that sweeps a known pattern into every entry after reset, one entry per clock.
module register_file_init
   import register_file_init_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit INIT_MODE  = 1'b1,
   parameter bit BYPASS     = 1'b1
) (
   input logic                 clk,
   input logic                 reset,
   register_file_init_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_next;
   logic                  w_init_we;
   logic                  w_run_we;
   logic                  w_ready;
   logic [DATA_WIDTH-1:0] w_init_val;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // The counter wraps to 0 on the edge that writes the last entry.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_init_we    = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_init_we  = 1'b1;
            w_cnt_next = r_cnt + ADDR_WIDTH'(1);
            if (r_cnt == '1) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_state_next = ST_RUN;
         end
         default: begin
            w_state_next = ST_INIT;
         end
      endcase
   end

   assign w_ready    = (r_state == ST_RUN);
   assign w_init_val = INIT_MODE ? DATA_WIDTH'(r_cnt) : '0;
   assign w_run_we   = w_ready && bus.regWrite &&
                       !(ZERO_REG && (bus.writeRegister == '0));

   // Storage has no reset of its own; reset only stalls the sweep.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_init_we) begin
            r_mem[r_cnt] <= w_init_val;
         end else if (w_run_we) begin
            r_mem[bus.writeRegister] <= bus.writeData;
         end
      end
   end

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
   ) u_rd1 (
      .i_ready  (w_ready),
      .i_raddr  (bus.readRegister1),
      .i_stored (r_mem[bus.readRegister1]),
      .i_we     (bus.regWrite),
      .i_waddr  (bus.writeRegister),
      .i_wdata  (bus.writeData),
      .o_rdata  (bus.readData1)
   );

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
   ) u_rd2 (
      .i_ready  (w_ready),
      .i_raddr  (bus.readRegister2),
      .i_stored (r_mem[bus.readRegister2]),
      .i_we     (bus.regWrite),
      .i_waddr  (bus.writeRegister),
      .i_wdata  (bus.writeData),
      .o_rdata  (bus.readData2)
   );

   assign bus.ready     = w_ready;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_register_file_init.sv
// Bench for register_file_init: a driver pushes expected reads from a reference model, a negedge monitor compares.
module tb_register_file_init;
   import register_file_init_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 2 ** AW;
   localparam int EW    = 1 + 2 * DW;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   register_file_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   register_file_init #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .ZERO_REG   (1'b1),
      .INIT_MODE  (1'b1),
      .BYPASS     (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // ready is simply "DEPTH low-reset edges have elapsed since the last reset edge".
   logic [DW-1:0] model_mem [DEPTH];
   int            model_low_edges;
   logic          model_ready;

   function automatic logic [DW-1:0] model_read(input int r, input logic we,
                                                input int wa, input logic [DW-1:0] wd);
      if (!model_ready) return '0;
      if (r == 0) return '0;
      if (we && r == wa) return wd;
      return model_mem[r];
   endfunction

   task automatic model_edge(input logic rst, input logic we, input int wa,
                             input logic [DW-1:0] wd);
      if (rst) begin
         model_low_edges = 0;
         model_ready     = 1'b0;
      end else if (!model_ready) begin
         model_mem[model_low_edges] = DW'(model_low_edges);
         model_low_edges++;
         if (model_low_edges == DEPTH) model_ready = 1'b1;
      end else if (we && wa != 0) begin
         model_mem[wa] = wd;
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [EW-1:0] e;
         e = exp_q.pop_front();
         checks++;
         if (bus.ready !== e[EW-1]) begin
            errors++;
            $display("FAIL ready @%0t: got %b exp %b", $time, bus.ready, e[EW-1]);
         end
         checks++;
         if (bus.readData1 !== e[2*DW-1:DW]) begin
            errors++;
            $display("FAIL readData1 @%0t idx=%0d: got %h exp %h", $time,
                     bus.readRegister1, bus.readData1, e[2*DW-1:DW]);
         end
         checks++;
         if (bus.readData2 !== e[DW-1:0]) begin
            errors++;
            $display("FAIL readData2 @%0t idx=%0d: got %h exp %h", $time,
                     bus.readRegister2, bus.readData2, e[DW-1:0]);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic cycle(input logic rst, input logic we, input int wa,
                        input logic [DW-1:0] wd, input int r1, input int r2);
      reset             = rst;
      bus.regWrite      = we;
      bus.writeRegister = AW'(wa);
      bus.writeData     = wd;
      bus.readRegister1 = AW'(r1);
      bus.readRegister2 = AW'(r2);
      exp_q.push_back({model_ready, model_read(r1, we, wa, wd), model_read(r2, we, wa, wd)});
      @(posedge clk);
      model_edge(rst, we, wa, wd);
      #1;
   endtask

   task automatic idle_read(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 1'b0, 0, '0, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      end
   endtask

   task automatic sweep_with_ignored_writes(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 1'b1, 3, 32'h0000_00AA, $urandom_range(0, DEPTH - 1), 3);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks            = 0;
      errors            = 0;
      model_low_edges   = 0;
      model_ready       = 1'b0;
      reset             = 1'b1;
      bus.regWrite      = 1'b0;
      bus.writeRegister = '0;
      bus.writeData     = '0;
      bus.readRegister1 = '0;
      bus.readRegister2 = '0;
      @(posedge clk);
      model_edge(1'b1, 1'b0, 0, '0);
      #1;

      // Reset held, then a full sweep with writes that must be ignored.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, '0, 5, 31);
      sweep_with_ignored_writes(DEPTH);
      cycle(1'b0, 1'b0, 0, '0, 5, 31);
      cycle(1'b0, 1'b0, 0, '0, 3, 0);

      // Plain write then read-back; untouched neighbour keeps its init value.
      cycle(1'b0, 1'b1, 7, 32'hDEAD_BEEF, 1, 2);
      cycle(1'b0, 1'b0, 0, '0, 7, 8);

      // Same-cycle bypass on both ports.
      cycle(1'b0, 1'b1, 9, 32'h0000_1234, 9, 9);
      cycle(1'b0, 1'b0, 0, '0, 9, 10);

      // Writes to the hardwired zero register, with bypass conditions met.
      cycle(1'b0, 1'b1, 0, 32'hFFFF_FFFF, 0, 0);
      cycle(1'b0, 1'b0, 0, '0, 0, 7);

      // Randomised traffic biased towards low indices and read/write collisions.
      for (int i = 0; i < 300; i++) begin
         int wa, r1, r2;
         wa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
         r1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
         r2 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, wa, $urandom(), r1, r2);
      end
      for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, 0, '0, i % DEPTH, 7);

      // Overwrite some entries, then restart the sweep part-way through.
      cycle(1'b0, 1'b1, 7, 32'hDEAD_BEEF, 7, 0);
      cycle(1'b0, 1'b1, 3, 32'h5555_5555, 7, 3);
      cycle(1'b1, 1'b0, 0, '0, 7, 3);
      idle_read(10);
      cycle(1'b1, 1'b0, 0, '0, 7, 3);
      sweep_with_ignored_writes(DEPTH);
      cycle(1'b0, 1'b0, 0, '0, 7, 3);
      cycle(1'b0, 1'b0, 0, '0, 31, 0);
      idle_read(4);

      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries never compared", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
